ctrl_cnt_grp_seq: RTL and testbench
===================================

// Module: ctrl_cnt_grp_seq
// PURPOSE
//  Parametrised filter-group sequencer driving the AC2/AC3 output-mux selects.
//  Steps a group index 1..max_q on each valid_in and wraps; counts complete passes up to max_pass.
//  Produces remW (remaining-groups flag) for the control FSM, plus last-group and done status.
//  Supports cyclic or one-shot mode, with a config range check; sits between the DP_CTRL FSM and the AC muxes.
// PARAMETERS
//  N_GRP   4                     max groups per pass (= mux inputs); >=2
//  PASS_W  8                     width of pass counter / max_pass
//  SEL_W   $clog2(N_GRP)         derived; mux select width
//  CNT_W   $clog2(N_GRP+1)       derived; group index width
// PORTS
//  clk       in   1       clock, rising edge
//  rst_n     in   1       reset, asynchronous, active-low
//  cnt_clear in   1       synchronous clear to IDLE
//  cnt_load  in   1       capture max_val/max_pass/mode; (re)start run
//  max_val   in   CNT_W   groups per pass (1..N_GRP)
//  max_pass  in   PASS_W  passes before done (one-shot), or wrap period (cyclic); 0 = 2^PASS_W
//  mode      in   1       0 = cyclic, 1 = one-shot
//  valid_in  in   1       advance strobe (valid_ac3)
//  sel_mux   out  SEL_W   mux select = idx-1
//  remW      out  1       1 = groups remain in current pass
//  last_grp  out  1       1-cycle pulse on wrap (pass complete)
//  pass_cnt  out  PASS_W  completed passes in current run
//  busy      out  1       state == RUN
//  done      out  1       one-shot complete; held until clear/load
//  cfg_err   out  1       last load was clamped; sticky until clear/load
// BEHAVIOUR
//  Reset: state=IDLE, idx=1, max_q=0, pass_cnt=0, remW=1, last_grp=0, done=0, cfg_err=0, busy=0.
//  Priority per cycle: cnt_clear > cnt_load > valid_in.
//  cnt_clear (any state): same values as reset; IDLE.
//  cnt_load (any state): max_q<=max_val, idx<=1, pass_cnt<=0, done<=0, state<=RUN.
//   If max_val==0 or max_val>N_GRP: max_q<=N_GRP and cfg_err<=1, else cfg_err<=0.
//  RUN, valid_in=1: if idx<max_q then idx++; else idx<=1, last_grp<=1 (next cycle, 1 cycle wide),
//   pass_cnt<=pass_cnt+1 (mod max_pass in cyclic mode, wraps to 0).
//   One-shot: the wrap that makes pass_cnt==max_pass -> state DONE, done<=1; pass_cnt holds max_pass.
//  IDLE/DONE: valid_in is ignored; idx and pass_cnt hold.
//  sel_mux: combinational from idx register: idx-1; out-of-range idx -> 0.
//  remW: registered; remW<=(idx!=max_q) from current-cycle idx, so it lags idx by one cycle.
//   It is forced to 1 on reset/clear/load. In IDLE, max_q=0, so remW=1.
//  max_val==1: idx stays 1; every valid_in is a wrap; remW=0 from the 2nd cycle of RUN.
//  Counter arithmetic is unsigned; no overflow beyond the stated wraps; pass_cnt never exceeds max_pass.
//  Asynchronous reset mid-run aborts immediately; no state is retained.
// STRUCTURE
//  ctrl_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} grp_state_t; MODE_CYCLIC/MODE_ONESHOT constants.
//  Sub-module ctrl_wrap_cnt #(W): load/clear/en, wraps at a runtime max and emits a wrap pulse.
//   It is instantiated twice: group index (wrap to 1) and pass counter (wrap to 0).
//  Top level: FSM, config clamp, remW/last_grp/done registers, sel_mux decode.
// TESTING (N_GRP=4, PASS_W=8)
//  1 Reset then idle: valid_in pulses -> sel_mux=0, remW=1, busy=0, pass_cnt=0 throughout.
//  2 Cyclic walk: load max_val=3, max_pass=2, mode=0; 7 valid_in -> sel 0,1,2,0,1,2,0.
//    Check last_grp pulses after the 3rd and 6th strobes; pass_cnt 1 then 0; remW=0 one cycle after idx=3.
//  3 One-shot: load max_val=2, max_pass=3; 6 valid_in -> done=1 after the 6th, pass_cnt=3.
//    Check further valid_in is ignored and busy=0.
//  4 Clamp: load max_val=0, then max_val=7 -> cfg_err=1, max_q=4 (sel reaches 3).
//    Then load max_val=4 -> cfg_err=0.
//  5 Simultaneous: cnt_clear+cnt_load+valid_in in the same cycle -> IDLE.
//    Check cnt_load+valid_in -> idx=1 (load wins), pass_cnt=0.
//  6 Async rst_n low mid-RUN at idx=3 -> outputs at reset values immediately; load restarts cleanly.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the filter-group sequencer.
// Imported by the top level and the testbench.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } grp_state_t;

  localparam logic MODE_CYCLIC  = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/ctrl_cnt_grp_seq_if.sv
// Control/status bundle between the DP_CTRL FSM and the group sequencer.
// master drives config and strobes; slave is the sequencer.
interface ctrl_cnt_grp_seq_if #(
  parameter int N_GRP  = 4,
  parameter int PASS_W = 8
);
  localparam int SEL_W = $clog2(N_GRP);
  localparam int CNT_W = $clog2(N_GRP + 1);

  logic              cnt_clear;
  logic              cnt_load;
  logic [CNT_W-1:0]  max_val;
  logic [PASS_W-1:0] max_pass;
  logic              mode;
  logic              valid_in;
  logic [SEL_W-1:0]  sel_mux;
  logic              remW;
  logic              last_grp;
  logic [PASS_W-1:0] pass_cnt;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport master (
    output cnt_clear, cnt_load, max_val,
    output max_pass, mode, valid_in,
    input  sel_mux, remW, last_grp,
    input  pass_cnt, busy, done, cfg_err
  );

  modport slave (
    input  cnt_clear, cnt_load, max_val,
    input  max_pass, mode, valid_in,
    output sel_mux, remW, last_grp,
    output pass_cnt, busy, done, cfg_err
  );

endinterface

// File: rtl/ctrl_wrap_cnt.sv
// Up-counter that returns to BASE after reaching a runtime top value.
// wrap flags the enabled step taken at top; wrap_en=0 lets it count past.
module ctrl_wrap_cnt #(
  parameter int           W    = 4,
  parameter logic [W-1:0] BASE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         en,
  input  logic         wrap_en,
  input  logic [W-1:0] top,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt >= top);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= BASE;
    end else if (clear || load) begin
      cnt <= BASE;
    end else if (en) begin
      cnt <= (wrap && wrap_en) ? BASE : cnt + W'(1);
    end
  end

endmodule

// File: rtl/ctrl_cnt_grp_seq.sv
// Filter-group sequencer: steps the AC2/AC3 mux select per valid strobe,
// counts passes, and reports remaining-groups, last-group and done status.
import ctrl_pkg::*;

module ctrl_cnt_grp_seq #(
  parameter int N_GRP  = 4,
  parameter int PASS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  ctrl_cnt_grp_seq_if.slave  bus
);

  localparam int SEL_W = $clog2(N_GRP);
  localparam int CNT_W = $clog2(N_GRP + 1);
  localparam logic [CNT_W-1:0] N_GRP_C = CNT_W'(N_GRP);

  grp_state_t        state;
  logic [CNT_W-1:0]  max_q;
  logic [CNT_W-1:0]  idx;
  logic [PASS_W-1:0] max_pass_q;
  logic [PASS_W-1:0] pass_cnt;
  logic [PASS_W-1:0] pass_top;
  logic              mode_q;
  logic              remw_q;
  logic              last_q;
  logic              done_q;
  logic              err_q;
  logic              grp_en;
  logic              grp_wrap;
  logic              pass_wrap;
  logic              clamp;
  logic              idx_ok;

  assign grp_en = (state == RUN) && bus.valid_in
               && !bus.cnt_clear && !bus.cnt_load;

  // max_pass of 0 gives top = all ones, i.e. a period of 2^PASS_W
  assign pass_top = max_pass_q - PASS_W'(1);

  assign clamp = (bus.max_val == '0)
              || (bus.max_val > N_GRP_C);

  ctrl_wrap_cnt #(
    .W    (CNT_W),
    .BASE (CNT_W'(1))
  ) u_grp (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.cnt_clear),
    .load    (bus.cnt_load),
    .en      (grp_en),
    .wrap_en (1'b1),
    .top     (max_q),
    .cnt     (idx),
    .wrap    (grp_wrap)
  );

  // one-shot runs count up to max_pass and hold there
  ctrl_wrap_cnt #(
    .W    (PASS_W),
    .BASE ('0)
  ) u_pass (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.cnt_clear),
    .load    (bus.cnt_load),
    .en      (grp_wrap),
    .wrap_en (mode_q == MODE_CYCLIC),
    .top     (pass_top),
    .cnt     (pass_cnt),
    .wrap    (pass_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      max_q      <= '0;
      max_pass_q <= '0;
      mode_q     <= MODE_CYCLIC;
      remw_q     <= 1'b1;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (bus.cnt_clear) begin
      state      <= IDLE;
      max_q      <= '0;
      max_pass_q <= '0;
      mode_q     <= MODE_CYCLIC;
      remw_q     <= 1'b1;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (bus.cnt_load) begin
      state      <= RUN;
      max_q      <= clamp ? N_GRP_C : bus.max_val;
      max_pass_q <= bus.max_pass;
      mode_q     <= bus.mode;
      remw_q     <= 1'b1;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= clamp;
    end else begin
      remw_q <= (idx != max_q);
      last_q <= grp_wrap;
      unique case (1'b1)
        (state == RUN): begin
          if (grp_wrap && pass_wrap
              && mode_q == MODE_ONESHOT) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign idx_ok = (idx != '0) && (idx <= N_GRP_C);

  assign bus.sel_mux  = idx_ok ? SEL_W'(idx - CNT_W'(1))
                               : '0;
  assign bus.remW     = remw_q;
  assign bus.last_grp = last_q;
  assign bus.pass_cnt = pass_cnt;
  assign bus.busy     = (state == RUN);
  assign bus.done     = done_q;
  assign bus.cfg_err  = err_q;

endmodule

// File: tb/tb_ctrl_cnt_grp_seq.sv
// Directed bench for ctrl_cnt_grp_seq with hand-computed expectations.
// N_GRP=4, PASS_W=8; outputs sampled 1ns after the rising edge.
module tb_ctrl_cnt_grp_seq;

  localparam int N_GRP  = 4;
  localparam int PASS_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ctrl_cnt_grp_seq_if #(
    .N_GRP  (N_GRP),
    .PASS_W (PASS_W)
  ) bus ();

  ctrl_cnt_grp_seq #(
    .N_GRP  (N_GRP),
    .PASS_W (PASS_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int mv,
                         input int mp,
                         input logic md);
    bus.max_val  = 3'(mv);
    bus.max_pass = 8'(mp);
    bus.mode     = md;
    bus.cnt_load = 1'b1;
    step();
    bus.cnt_load = 1'b0;
  endtask

  int t2_sel [7] = '{1, 2, 0, 1, 2, 0, 1};
  int t2_last[7] = '{0, 0, 1, 0, 0, 1, 0};
  int t2_pass[7] = '{0, 0, 1, 1, 1, 0, 0};
  int t2_remw[7] = '{1, 1, 0, 1, 1, 0, 1};

  int t3_sel [6] = '{1, 0, 1, 0, 1, 0};
  int t3_pass[6] = '{0, 1, 1, 2, 2, 3};
  int t3_done[6] = '{0, 0, 0, 0, 0, 1};
  int t3_busy[6] = '{1, 1, 1, 1, 1, 0};

  int t4_sel [4] = '{1, 2, 3, 0};

  initial begin
    bus.cnt_clear = 1'b0;
    bus.cnt_load  = 1'b0;
    bus.max_val   = '0;
    bus.max_pass  = '0;
    bus.mode      = 1'b0;
    bus.valid_in  = 1'b0;

    // 1: reset, then strobes in IDLE do nothing
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst sel",  bus.sel_mux,  0);
    chk("rst remW", bus.remW,     1);
    chk("rst busy", bus.busy,     0);
    chk("rst pass", bus.pass_cnt, 0);
    chk("rst last", bus.last_grp, 0);
    chk("rst done", bus.done,     0);
    chk("rst err",  bus.cfg_err,  0);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle sel[%0d]", i),  bus.sel_mux,  0);
      chk($sformatf("idle remW[%0d]", i), bus.remW,     1);
      chk($sformatf("idle busy[%0d]", i), bus.busy,     0);
      chk($sformatf("idle pass[%0d]", i), bus.pass_cnt, 0);
    end
    bus.valid_in = 1'b0;

    // 2: cyclic walk, 3 groups, pass period 2
    do_load(3, 2, 1'b0);
    chk("cyc busy", bus.busy,    1);
    chk("cyc sel0", bus.sel_mux, 0);
    chk("cyc remW0", bus.remW,   1);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("cyc sel[%0d]", i),  bus.sel_mux,  t2_sel[i]);
      chk($sformatf("cyc last[%0d]", i), bus.last_grp, t2_last[i]);
      chk($sformatf("cyc pass[%0d]", i), bus.pass_cnt, t2_pass[i]);
      chk($sformatf("cyc remW[%0d]", i), bus.remW,     t2_remw[i]);
    end
    bus.valid_in = 1'b0;
    step();
    chk("cyc hold sel",  bus.sel_mux,  1);
    chk("cyc hold last", bus.last_grp, 0);

    // 3: one-shot, 2 groups x 3 passes
    do_load(2, 3, 1'b1);
    chk("one busy0", bus.busy, 1);
    chk("one pass0", bus.pass_cnt, 0);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("one sel[%0d]", i),  bus.sel_mux,  t3_sel[i]);
      chk($sformatf("one pass[%0d]", i), bus.pass_cnt, t3_pass[i]);
      chk($sformatf("one done[%0d]", i), bus.done,     t3_done[i]);
      chk($sformatf("one busy[%0d]", i), bus.busy,     t3_busy[i]);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("one ign sel[%0d]", i),  bus.sel_mux,  0);
      chk($sformatf("one ign pass[%0d]", i), bus.pass_cnt, 3);
      chk($sformatf("one ign done[%0d]", i), bus.done,     1);
      chk($sformatf("one ign busy[%0d]", i), bus.busy,     0);
      chk($sformatf("one ign last[%0d]", i), bus.last_grp, 0);
    end
    bus.valid_in = 1'b0;

    // 4: config clamp
    do_load(0, 0, 1'b0);
    chk("clamp0 err",  bus.cfg_err, 1);
    chk("clamp0 busy", bus.busy,    1);
    chk("clamp0 done", bus.done,    0);
    do_load(7, 0, 1'b0);
    chk("clamp7 err", bus.cfg_err, 1);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("clamp sel[%0d]", i), bus.sel_mux, t4_sel[i]);
    end
    bus.valid_in = 1'b0;
    chk("clamp last", bus.last_grp, 1);
    chk("clamp pass", bus.pass_cnt, 1);
    do_load(4, 0, 1'b0);
    chk("ok4 err", bus.cfg_err, 0);

    // 4b: single group per pass
    do_load(1, 2, 1'b0);
    chk("one-grp remW0", bus.remW, 1);
    bus.valid_in = 1'b1;
    step();
    chk("one-grp last1", bus.last_grp, 1);
    chk("one-grp pass1", bus.pass_cnt, 1);
    chk("one-grp remW1", bus.remW,     0);
    step();
    chk("one-grp last2", bus.last_grp, 1);
    chk("one-grp pass2", bus.pass_cnt, 0);
    chk("one-grp sel2",  bus.sel_mux,  0);
    bus.valid_in = 1'b0;
    step();
    chk("one-grp last3", bus.last_grp, 0);
    chk("one-grp remW3", bus.remW,     0);

    // 5: clear beats load beats valid
    do_load(4, 0, 1'b0);
    bus.valid_in = 1'b1;
    step();
    step();
    chk("pri pre sel", bus.sel_mux, 2);
    bus.cnt_clear = 1'b1;
    bus.cnt_load  = 1'b1;
    bus.max_val   = 3'd0;
    step();
    bus.cnt_clear = 1'b0;
    bus.cnt_load  = 1'b0;
    bus.valid_in  = 1'b0;
    chk("clr busy", bus.busy,     0);
    chk("clr sel",  bus.sel_mux,  0);
    chk("clr remW", bus.remW,     1);
    chk("clr err",  bus.cfg_err,  0);
    chk("clr pass", bus.pass_cnt, 0);
    do_load(3, 2, 1'b0);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("ldv pre sel",  bus.sel_mux,  1);
    chk("ldv pre pass", bus.pass_cnt, 1);
    bus.max_val  = 3'd3;
    bus.cnt_load = 1'b1;
    step();
    bus.cnt_load = 1'b0;
    chk("ldv sel",  bus.sel_mux,  0);
    chk("ldv pass", bus.pass_cnt, 0);
    chk("ldv busy", bus.busy,     1);
    chk("ldv last", bus.last_grp, 0);
    step();
    chk("ldv next sel", bus.sel_mux, 1);
    bus.valid_in = 1'b0;

    // 6: async reset mid-run
    do_load(7, 5, 1'b0);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 6; i++) step();
    bus.valid_in = 1'b0;
    chk("arst pre sel",  bus.sel_mux,  2);
    chk("arst pre pass", bus.pass_cnt, 1);
    chk("arst pre err",  bus.cfg_err,  1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst sel",  bus.sel_mux,  0);
    chk("arst busy", bus.busy,     0);
    chk("arst pass", bus.pass_cnt, 0);
    chk("arst err",  bus.cfg_err,  0);
    chk("arst remW", bus.remW,     1);
    chk("arst last", bus.last_grp, 0);
    step();
    rst_n = 1'b1;
    do_load(2, 1, 1'b1);
    chk("re busy", bus.busy,    1);
    chk("re sel",  bus.sel_mux, 0);
    bus.valid_in = 1'b1;
    step();
    chk("re sel1", bus.sel_mux, 1);
    step();
    bus.valid_in = 1'b0;
    chk("re done", bus.done,     1);
    chk("re pass", bus.pass_cnt, 1);
    chk("re busy2", bus.busy,    0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
